// File: rtl/dice_turn_ctrl.sv
// Two-player turn scheduler for a shared dice block.
// Grants the dice to one player at a time and drives the dice button while
// that player holds theirs. It captures the settled throw, adds it to the
// active player's score, passes the turn and declares a winner at TARGET.
// Player buttons are registered once on entry. Every FSM decision therefore
// lands one edge after the edge that samples the button. As a result, roll
// stays high through the cycle after the button falls, and the score lands
// three edges after the button is seen released.
module dice_turn_ctrl #(
  parameter int SCORE_W  = 6,
  parameter int TARGET   = 20,
  parameter int MIN_HOLD = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_a,
  input  logic               btn_b,
  input  logic [2:0]         throw,
  output logic               roll,
  output logic               turn,
  output logic [SCORE_W-1:0] score_a,
  output logic [SCORE_W-1:0] score_b,
  output logic               score_vld,
  output logic               bad_throw,
  output logic               game_over,
  output logic               winner
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_ROLL,
    S_SETTLE,
    S_ADD,
    S_DONE
  } state_t;

  localparam logic [SCORE_W-1:0] TARGET_V   = SCORE_W'(TARGET);
  localparam logic [3:0]         MIN_HOLD_V = 4'(MIN_HOLD);
  localparam logic [3:0]         HOLD_MAX   = 4'd15;

  state_t             state, state_nxt;
  logic               btn_a_p0, btn_b_p0;
  logic               act_btn;
  logic [3:0]         hold_cnt, hold_cnt_nxt;
  logic [SCORE_W-1:0] score_act;
  logic [SCORE_W-1:0] sum;
  logic               throw_ok;
  logic               add_en;
  logic               bad_en;
  logic               win;
  logic               clear;

  // Saturating add of a dice face onto a score; never wraps.
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [2:0]         b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W-2){1'b0}}, b};
    if (s[SCORE_W]) begin
      return {SCORE_W{1'b1}};
    end
    return s[SCORE_W-1:0];
  endfunction

  assign act_btn   = turn ? btn_b_p0 : btn_a_p0;
  assign score_act = turn ? score_b : score_a;
  assign sum       = sat_add(score_act, throw);
  assign throw_ok  = (throw != 3'd0) && (throw != 3'd7);

  // Input stage: register both player buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_a_p0 <= 1'b0;
      btn_b_p0 <= 1'b0;
    end else begin
      btn_a_p0 <= btn_a;
      btn_b_p0 <= btn_b;
    end
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    add_en       = 1'b0;
    bad_en       = 1'b0;
    win          = 1'b0;
    clear        = 1'b0;
    case (state)
      S_WAIT: begin
        if (act_btn) begin
          state_nxt    = S_ROLL;
          hold_cnt_nxt = 4'd1;
        end
      end
      S_ROLL: begin
        if (act_btn) begin
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt_nxt = hold_cnt + 4'd1;
          end
        end else if (hold_cnt >= MIN_HOLD_V) begin
          state_nxt = S_SETTLE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_SETTLE: begin
        state_nxt = S_ADD;
      end
      S_ADD: begin
        if (throw_ok) begin
          add_en = 1'b1;
          if (sum >= TARGET_V) begin
            win       = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT;
          end
        end else begin
          bad_en    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        if (btn_a_p0 && btn_b_p0) begin
          clear     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      default: begin
        state_nxt = S_WAIT;
      end
    endcase
  end

  // Control stage: state, hold counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_WAIT;
      hold_cnt  <= 4'd0;
      roll      <= 1'b0;
      game_over <= 1'b0;
      score_vld <= 1'b0;
      bad_throw <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_cnt_nxt;
      roll      <= (state_nxt == S_ROLL);
      game_over <= (state_nxt == S_DONE);
      score_vld <= add_en;
      bad_throw <= bad_en;
    end
  end

  // Score stage: accumulate the counted throw, pass turn, latch the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_a <= '0;
      score_b <= '0;
      turn    <= 1'b0;
      winner  <= 1'b0;
    end else if (clear) begin
      score_a <= '0;
      score_b <= '0;
      turn    <= 1'b0;
      winner  <= 1'b0;
    end else if (add_en) begin
      if (turn) begin
        score_b <= sum;
      end else begin
        score_a <= sum;
      end
      if (win) begin
        winner <= turn;
      end else begin
        turn <= ~turn;
      end
    end
  end

endmodule

// File: tb/tb_dice_turn_ctrl.sv
// Directed bench for dice_turn_ctrl: plays scripted turns with fixed throws
// and compares pulses, scores, turn and game status to hand-computed values.
module tb_dice_turn_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_a;
  logic       btn_b;
  logic [2:0] throw;
  logic       roll;
  logic       turn;
  logic [5:0] score_a;
  logic [5:0] score_b;
  logic       score_vld;
  logic       bad_throw;
  logic       game_over;
  logic       winner;

  int checks;
  int failures;
  int n_roll;
  int n_vld;
  int n_bad;

  dice_turn_ctrl #(
    .SCORE_W (6),
    .TARGET  (20),
    .MIN_HOLD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_a    (btn_a),
    .btn_b    (btn_b),
    .throw    (throw),
    .roll     (roll),
    .turn     (turn),
    .score_a  (score_a),
    .score_b  (score_b),
    .score_vld(score_vld),
    .bad_throw(bad_throw),
    .game_over(game_over),
    .winner   (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the rising edge, accumulating pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    n_roll += int'(roll);
    n_vld  += int'(score_vld);
    n_bad  += int'(bad_throw);
  endtask

  // Player pl presses for n cycles with throw t on the dice, then releases
  // and waits 4 cycles: the score result is visible after the last one.
  task automatic play(input bit pl, input int n, input logic [2:0] t);
    throw  = t;
    n_roll = 0;
    n_vld  = 0;
    n_bad  = 0;
    if (pl) btn_b = 1'b1;
    else    btn_a = 1'b1;
    repeat (n) tick();
    btn_a = 1'b0;
    btn_b = 1'b0;
    repeat (4) tick();
  endtask

  task automatic expect_turn(input string tag, input int rolls, input int vlds,
                             input int bads, input int sa, input int sb,
                             input int tn, input int go);
    chk({tag, ".roll_cycles"}, 32'(n_roll), 32'(rolls));
    chk({tag, ".vld_pulses"},  32'(n_vld),  32'(vlds));
    chk({tag, ".bad_pulses"},  32'(n_bad),  32'(bads));
    chk({tag, ".score_a"},     32'(score_a), 32'(sa));
    chk({tag, ".score_b"},     32'(score_b), 32'(sb));
    chk({tag, ".turn"},        32'(turn),    32'(tn));
    chk({tag, ".game_over"},   32'(game_over), 32'(go));
  endtask

  task automatic expect_all_zero(input string tag);
    chk({tag, ".roll"},      32'(roll),      0);
    chk({tag, ".turn"},      32'(turn),      0);
    chk({tag, ".score_a"},   32'(score_a),   0);
    chk({tag, ".score_b"},   32'(score_b),   0);
    chk({tag, ".score_vld"}, 32'(score_vld), 0);
    chk({tag, ".bad_throw"}, 32'(bad_throw), 0);
    chk({tag, ".game_over"}, 32'(game_over), 0);
    chk({tag, ".winner"},    32'(winner),    0);
  endtask

  task automatic clear_game(input string tag);
    btn_a = 1'b1;
    btn_b = 1'b1;
    tick();
    btn_a = 1'b0;
    btn_b = 1'b0;
    tick();
    expect_all_zero(tag);
    tick();
    chk({tag, ".roll_after"}, 32'(roll), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    btn_a    = 1'b0;
    btn_b    = 1'b0;
    throw    = 3'd3;
    repeat (2) tick();
    expect_all_zero("reset");
    rst = 1'b0;
    tick();

    // Short press by A: roll 2 cycles, nothing scored, turn kept.
    play(1'b0, 2, 3'd3);
    expect_turn("short_a", 2, 0, 0, 0, 0, 0, 0);

    // Non-granted B button ignored.
    play(1'b1, 10, 3'd3);
    expect_turn("ignore_b", 0, 0, 0, 0, 0, 0, 0);

    // A holds 6, throw 3.
    play(1'b0, 6, 3'd3);
    chk("a3.vld_now", 32'(score_vld), 1);
    expect_turn("a3", 6, 1, 0, 3, 0, 1, 0);
    tick();
    chk("a3.vld_width", 32'(score_vld), 0);

    // Hold of 3 is one short of MIN_HOLD; hold of 4 counts.
    play(1'b1, 3, 3'd6);
    expect_turn("hold3", 3, 0, 0, 3, 0, 1, 0);
    play(1'b1, 4, 3'd6);
    expect_turn("hold4", 4, 1, 0, 3, 6, 0, 0);

    // Bad throws 7 and 0: pulse bad_throw, no change.
    play(1'b0, 5, 3'd7);
    chk("bad7.now", 32'(bad_throw), 1);
    expect_turn("bad7", 5, 0, 1, 3, 6, 0, 0);
    tick();
    chk("bad7.width", 32'(bad_throw), 0);
    play(1'b0, 4, 3'd0);
    expect_turn("bad0", 4, 0, 1, 3, 6, 0, 0);

    // Build B up to 18, then B throws 4 -> 22 and wins.
    play(1'b0, 4, 3'd5);
    expect_turn("a8", 4, 1, 0, 8, 6, 1, 0);
    play(1'b1, 4, 3'd6);
    expect_turn("b12", 4, 1, 0, 8, 12, 0, 0);
    play(1'b0, 4, 3'd1);
    expect_turn("a9", 4, 1, 0, 9, 12, 1, 0);
    play(1'b1, 4, 3'd6);
    expect_turn("b18", 4, 1, 0, 9, 18, 0, 0);
    play(1'b0, 4, 3'd2);
    expect_turn("a11", 4, 1, 0, 11, 18, 1, 0);
    play(1'b1, 4, 3'd4);
    expect_turn("b22", 4, 1, 0, 11, 22, 1, 1);
    chk("b22.winner", 32'(winner), 1);

    // In DONE single buttons do nothing; scores frozen.
    play(1'b0, 6, 3'd3);
    expect_turn("done_a", 0, 0, 0, 11, 22, 1, 1);
    play(1'b1, 6, 3'd3);
    expect_turn("done_b", 0, 0, 0, 11, 22, 1, 1);
    chk("done_b.winner", 32'(winner), 1);

    clear_game("clear1");

    // A reaches exactly TARGET (20) and wins.
    play(1'b0, 4, 3'd6);
    expect_turn("g2a6", 4, 1, 0, 6, 0, 1, 0);
    play(1'b1, 4, 3'd1);
    expect_turn("g2b1", 4, 1, 0, 6, 1, 0, 0);
    play(1'b0, 4, 3'd6);
    expect_turn("g2a12", 4, 1, 0, 12, 1, 1, 0);
    play(1'b1, 4, 3'd1);
    expect_turn("g2b2", 4, 1, 0, 12, 2, 0, 0);
    play(1'b0, 4, 3'd6);
    expect_turn("g2a18", 4, 1, 0, 18, 2, 1, 0);
    play(1'b1, 4, 3'd1);
    expect_turn("g2b3", 4, 1, 0, 18, 3, 0, 0);
    play(1'b0, 4, 3'd2);
    expect_turn("g2a20", 4, 1, 0, 20, 3, 0, 1);
    chk("g2a20.winner", 32'(winner), 0);

    clear_game("clear2");

    // Score once, then reset in the middle of B's roll.
    play(1'b0, 4, 3'd3);
    expect_turn("pre_rst", 4, 1, 0, 3, 0, 1, 0);
    btn_b = 1'b1;
    repeat (3) tick();
    chk("mid_roll.roll", 32'(roll), 1);
    #2;
    rst = 1'b1;
    #1;
    expect_all_zero("async_rst");
    btn_b = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    expect_all_zero("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
